// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: counter op codes,
// fetch FSM states and the default halt opcode.
package if_pkg;

   localparam logic [1:0] PC_OP_LOAD = 2'b00;
   localparam logic [1:0] PC_OP_HOLD = 2'b01;
   localparam logic [1:0] PC_OP_INC  = 2'b10;
   localparam logic [1:0] PC_OP_DEC  = 2'b11;

   localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction with its PC, holds, or
// flushes the valid bit. Flush wins over load.
module if_id_reg #(
   parameter int PC_W    = 4,
   parameter int INSTR_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               flush,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [PC_W-1:0]    load_pc,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   output logic               valid
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = load_instr;
         pc_d    = load_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign pc    = pc_q;
   assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: steers the external PC counter, reads instruction
// memory and fills IF/ID. Define IF_REWIND_EN to add the rewind input.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int         PC_W        = 4,
   parameter int         INSTR_W     = 16,
   parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc_in,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
`ifdef IF_REWIND_EN
   input  logic               rewind,
`endif
   input  logic               id_ready,
   output logic [1:0]         pc_op,
   output logic [PC_W-1:0]    pc_value,
   output logic               cnt_enable,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic               halted
);

   fetch_state_e state_q, state_d;
   logic         halted_q, halted_d;
   logic         ifid_load, ifid_flush;
   logic         stall;
   logic         is_halt;

   assign imem_addr = pc_in;
   assign stall     = instr_valid && !id_ready;
   assign is_halt   = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);

   always_comb begin
      state_d    = state_q;
      pc_op      = PC_OP_HOLD;
      pc_value   = pc_in;
      cnt_enable = 1'b1;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      case (state_q)
         S_INIT: begin
            // Counter clears on the next edge while disabled.
            cnt_enable = 1'b0;
            pc_value   = '0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            if (branch_taken) begin
               pc_op      = PC_OP_LOAD;
               pc_value   = branch_target;
               ifid_flush = 1'b1;
`ifdef IF_REWIND_EN
            end else if (rewind) begin
               pc_op      = PC_OP_DEC;
               ifid_flush = 1'b1;
`endif
            end else if (stall) begin
               pc_op = PC_OP_HOLD;
            end else if (is_halt) begin
               pc_op     = PC_OP_HOLD;
               ifid_load = 1'b1;
               state_d   = S_HALT;
            end else begin
               pc_op     = PC_OP_INC;
               ifid_load = 1'b1;
            end
         end
         S_HALT: begin
            // The captured halt instruction drains once, then IF/ID stays empty.
            if (instr_valid && id_ready) begin
               ifid_flush = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_INIT;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;

   if_id_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_if_id_reg (
      .clock      (clock),
      .reset      (reset),
      .load       (ifid_load),
      .flush      (ifid_flush),
      .load_instr (imem_data),
      .load_pc    (pc_in),
      .instr      (instr_out),
      .pc         (instr_pc),
      .valid      (instr_valid)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural PC counter and
// instruction memory; define IF_REWIND_EN to also cover rewind.
module tb_if_fetch_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  pc_in;
   logic [3:0]  imem_addr;
   logic [15:0] imem_data;
   logic        branch_taken = 1'b0;
   logic [3:0]  branch_target = 4'h0;
   logic        id_ready = 1'b1;
   logic [1:0]  pc_op;
   logic [3:0]  pc_value;
   logic        cnt_enable;
   logic [15:0] instr_out;
   logic [3:0]  instr_pc;
   logic        instr_valid;
   logic        halted;
`ifdef IF_REWIND_EN
   logic        rewind = 1'b0;
`endif

   logic [15:0] imem [16];
   logic [3:0]  cnt;
   int          n_chk  = 0;
   int          n_pass = 0;

   always #5 clock = ~clock;

   if_fetch_stage dut (
      .clock         (clock),
      .reset         (reset),
      .pc_in         (pc_in),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
`ifdef IF_REWIND_EN
      .rewind        (rewind),
`endif
      .id_ready      (id_ready),
      .pc_op         (pc_op),
      .pc_value      (pc_value),
      .cnt_enable    (cnt_enable),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .halted        (halted)
   );

   // Behavioural model of the downstream 4-bit PC counter.
   always @(posedge clock or posedge reset) begin
      if (reset) cnt <= 4'h0;
      else if (!cnt_enable) cnt <= 4'h0;
      else case (pc_op)
         2'b00: cnt <= pc_value;
         2'b01: cnt <= cnt;
         2'b10: cnt <= pc_value + 4'h1;
         default: cnt <= pc_value - 4'h1;
      endcase
   end
   assign pc_in     = cnt;
   assign imem_data = imem[imem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) imem[i] = 16'h1000 + 16'(i);
      step();
      step();
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_instr", 32'(instr_out), 32'h0);
      check("rst_pc", 32'(instr_pc), 32'h0);
      reset = 1'b0;
      check("init_cnt_en", 32'(cnt_enable), 32'd0);
      step();
      check("run_cnt_en", 32'(cnt_enable), 32'd1);
      check("run_pc_op", 32'(pc_op), 32'h2);
      check("run_addr", 32'(imem_addr), 32'h0);

      // Sequential fetch up to instr_pc=4 with PC=5 on the counter.
      for (int k = 0; k < 5; k++) begin
         step();
         check("seq_pc", 32'(instr_pc), 32'(k));
         check("seq_instr", 32'(instr_out), 32'h1000 + 32'(k));
         check("seq_valid", 32'(instr_valid), 32'd1);
      end
      check("seq_pc_in", 32'(pc_in), 32'h5);

      // Stall for three cycles.
      id_ready = 1'b0;
      #1;
      check("stall_op", 32'(pc_op), 32'h1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_pc", 32'(instr_pc), 32'h4);
         check("stall_instr", 32'(instr_out), 32'h1004);
         check("stall_pc_in", 32'(pc_in), 32'h5);
         check("stall_op_hold", 32'(pc_op), 32'h1);
      end
      id_ready = 1'b1;
      #1;
      check("release_op", 32'(pc_op), 32'h2);
      step();
      check("release_pc5", 32'(instr_pc), 32'h5);
      check("release_i5", 32'(instr_out), 32'h1005);
      step();
      check("release_pc6", 32'(instr_pc), 32'h6);

      // Branch while stalled.
      id_ready      = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 4'hA;
      #1;
      check("br_op", 32'(pc_op), 32'h0);
      check("br_value", 32'(pc_value), 32'hA);
      step();
      branch_taken = 1'b0;
      check("br_flush", 32'(instr_valid), 32'd0);
      check("br_pc_in", 32'(pc_in), 32'hA);
      id_ready = 1'b1;
      step();
      check("br_target_pc", 32'(instr_pc), 32'hA);
      check("br_target_i", 32'(instr_out), 32'h100A);

      // Wrap-around F -> 0.
      for (int k = 11; k < 16; k++) begin
         step();
         check("wrap_seq", 32'(instr_pc), 32'(k));
      end
      step();
      check("wrap_pc0", 32'(instr_pc), 32'h0);
      check("wrap_i0", 32'(instr_out), 32'h1000);

      // Halt at PC 3.
      imem[3] = 16'hF000;
      step();
      step();
      check("halt_pc_in", 32'(pc_in), 32'h3);
      check("halt_op", 32'(pc_op), 32'h1);
      step();
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_instr", 32'(instr_out), 32'hF000);
      check("halt_ipc", 32'(instr_pc), 32'h3);
      check("halt_valid", 32'(instr_valid), 32'd1);
      step();
      check("halt_drained", 32'(instr_valid), 32'd0);
      check("halt_hold_op", 32'(pc_op), 32'h1);
      branch_taken  = 1'b1;
      branch_target = 4'h7;
      #1;
      check("halt_br_ign", 32'(pc_op), 32'h1);
      step();
      branch_taken = 1'b0;
      check("halt_pc_stay", 32'(pc_in), 32'h3);
      check("halt_still", 32'(halted), 32'd1);
      check("halt_no_val", 32'(instr_valid), 32'd0);

      // Reset restarts from PC 0.
      imem[3] = 16'h1003;
      reset = 1'b1;
      step();
      check("rst2_halted", 32'(halted), 32'd0);
      check("rst2_instr", 32'(instr_out), 32'h0);
      reset = 1'b0;
      check("rst2_cnt_en", 32'(cnt_enable), 32'd0);
      step();
      step();
      check("rst2_pc0", 32'(instr_pc), 32'h0);
      check("rst2_i0", 32'(instr_out), 32'h1000);

`ifdef IF_REWIND_EN
      for (int k = 1; k < 6; k++) step();
      check("rw_pc_in", 32'(pc_in), 32'h6);
      rewind = 1'b1;
      #1;
      check("rw_op", 32'(pc_op), 32'h3);
      step();
      rewind = 1'b0;
      check("rw_flush", 32'(instr_valid), 32'd0);
      check("rw_pc_in5", 32'(pc_in), 32'h5);
      step();
      check("rw_ipc", 32'(instr_pc), 32'h5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
